// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: exception codes, stall
// patterns, FSM state encodings and the default exception entry address.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  // Stall patterns: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_PC   = 6'b000001;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [31:0] EXC_VECTOR  = 32'h0000_0020;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline controller (master) and the pipeline stages
// that raise hold requests and consume stall/flush controls (slave).
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;

  modport master (
    input  stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    output stall_o, flush_o, new_pc_o, stall_timeout_o
  );

  modport slave (
    output stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    input  stall_o, flush_o, new_pc_o, stall_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and emits a single
// timeout pulse when the run length reaches LIMIT, then saturates.
module stall_wdog #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic timeout
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Saturating at LIMIT keeps cnt away from LIMIT-1, so only one pulse per run.
  assign timeout = rst_n && en && !clr && (cnt == LIMIT - 8'd1);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: prioritised stage stalls, exception
// flush with redirect, a post-flush PC hold window and a stall watchdog.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = pipe_ctrl_pkg::EXC_VECTOR,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter logic [7:0]  WDOG_LIMIT     = 8'd255
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_ctrl_if.master      pif
);
  import pipe_ctrl_pkg::*;

  localparam logic [2:0] REC_LOAD = 3'(RECOVER_CYCLES - 1);

  state_e      state;
  logic [2:0]  rec_cnt;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdog_en;
  logic        wdog_clr;
  logic        exc_hit;

  function automatic logic [31:0] exc_target(input logic [31:0] code,
                                             input logic [31:0] epc);
    case (code)
      EXC_NONE:    exc_target = 32'h0;
      EXC_ERET:    exc_target = epc;
      EXC_INT, EXC_SYSCALL, EXC_BREAK, EXC_RI, EXC_OV, EXC_TRAP:
                   exc_target = EXC_VECTOR;
      default:     exc_target = EXC_VECTOR;
    endcase
  endfunction

  assign exc_hit = (state == ST_RUN) && (pif.excepttype_i != EXC_NONE);

  // Outputs are combinational on the current state so an exception or a
  // stall request takes effect in the same cycle it is raised.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (rst_n) begin
      case (state)
        ST_RUN: begin
          if (exc_hit) begin
            flush  = 1'b1;
            new_pc = exc_target(pif.excepttype_i, pif.cp0_epc_i);
          end else if (pif.stallreq_mem) begin
            stall = STALL_MEM;
          end else if (pif.stallreq_ex) begin
            stall = STALL_EX;
          end else if (pif.stallreq_id) begin
            stall = STALL_ID;
          end
        end
        ST_FLUSH, ST_RECOVER: stall = STALL_PC;
        default:              stall = STALL_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      rec_cnt <= 3'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_hit) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          state   <= ST_RECOVER;
          rec_cnt <= REC_LOAD;
        end
        ST_RECOVER: begin
          if (rec_cnt == 3'd0) state <= ST_RUN;
          else                 rec_cnt <= rec_cnt - 3'd1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign wdog_en  = (state == ST_RUN) && (stall != STALL_NONE);
  assign wdog_clr = !wdog_en;

  stall_wdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (wdog_en),
    .clr     (wdog_clr),
    .timeout (pif.stall_timeout_o)
  );

  assign pif.stall_o  = stall;
  assign pif.flush_o  = flush;
  assign pif.new_pc_o = new_pc;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, exception flush/recover,
// eret redirect, watchdog pulse and reset abort.
module tb_pipe_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   pulses;
  int   pulse_at;

  pipe_ctrl_if pif();

  pipe_ctrl #(
    .EXC_VECTOR     (32'h0000_0020),
    .RECOVER_CYCLES (2),
    .WDOG_LIMIT     (8'd255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    pif.stallreq_id  = 1'b0;
    pif.stallreq_ex  = 1'b0;
    pif.stallreq_mem = 1'b0;
    pif.excepttype_i = 32'h0;
    pif.cp0_epc_i    = 32'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clr_in();
    // Reset holds outputs low even with active requests and an exception
    pif.stallreq_mem = 1'b1;
    pif.excepttype_i = 32'h8;
    #3;
    chk("rst_stall", {26'h0, pif.stall_o}, 32'h0);
    chk("rst_flush", {31'h0, pif.flush_o}, 32'h0);
    chk("rst_newpc", pif.new_pc_o, 32'h0);
    chk("rst_tmo", {31'h0, pif.stall_timeout_o}, 32'h0);
    clr_in();
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stall", {26'h0, pif.stall_o}, 32'h0);

    // 40-cycle EX stall, no timeout
    next_cyc();
    pif.stallreq_ex = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("ex_stall", {26'h0, pif.stall_o}, 32'h0000_000f);
      chk("ex_tmo", {31'h0, pif.stall_timeout_o}, 32'h0);
      next_cyc();
    end
    pif.stallreq_ex = 1'b0;
    @(negedge clk);
    chk("ex_release", {26'h0, pif.stall_o}, 32'h0);

    // Priority without exception
    next_cyc();
    pif.stallreq_id = 1'b1;
    pif.stallreq_ex = 1'b1;
    @(negedge clk);
    chk("prio_ex_id", {26'h0, pif.stall_o}, 32'h0000_000f);
    next_cyc();
    pif.stallreq_mem = 1'b1;
    @(negedge clk);
    chk("prio_mem", {26'h0, pif.stall_o}, 32'h0000_001f);

    // Exception overrides stalls, then FLUSH + 2 RECOVER with requests ignored
    next_cyc();
    pif.stallreq_ex  = 1'b0;
    pif.excepttype_i = 32'h8;
    @(negedge clk);
    chk("exc_flush", {31'h0, pif.flush_o}, 32'h1);
    chk("exc_newpc", pif.new_pc_o, 32'h0000_0020);
    chk("exc_stall", {26'h0, pif.stall_o}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      @(negedge clk);
      chk("rec_stall", {26'h0, pif.stall_o}, 32'h1);
      chk("rec_flush", {31'h0, pif.flush_o}, 32'h0);
    end
    next_cyc();
    clr_in();
    pif.stallreq_id = 1'b1;
    @(negedge clk);
    chk("back_run", {26'h0, pif.stall_o}, 32'h0000_0007);

    // eret redirect; a new exception during RECOVER is ignored
    next_cyc();
    clr_in();
    pif.excepttype_i = 32'he;
    pif.cp0_epc_i    = 32'hBFC0_0100;
    @(negedge clk);
    chk("eret_flush", {31'h0, pif.flush_o}, 32'h1);
    chk("eret_newpc", pif.new_pc_o, 32'hBFC0_0100);
    next_cyc();
    pif.excepttype_i = 32'h0;
    @(negedge clk);
    chk("flush_newpc", pif.new_pc_o, 32'h0);
    pif.excepttype_i = 32'h1;
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      @(negedge clk);
      chk("recexc_flush", {31'h0, pif.flush_o}, 32'h0);
      chk("recexc_stall", {26'h0, pif.stall_o}, 32'h1);
    end
    next_cyc();
    pif.excepttype_i = 32'h0;
    @(negedge clk);
    chk("recexc_run", {26'h0, pif.stall_o}, 32'h0);

    // Unlisted nonzero code goes to the vector
    next_cyc();
    pif.excepttype_i = 32'h3;
    @(negedge clk);
    chk("other_newpc", pif.new_pc_o, 32'h0000_0020);
    next_cyc();
    pif.excepttype_i = 32'h0;
    next_cyc();
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("other_run", {26'h0, pif.stall_o}, 32'h0);

    // Watchdog: MEM stall held 300 cycles
    next_cyc();
    pulses   = 0;
    pulse_at = 0;
    pif.stallreq_mem = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (pif.stall_timeout_o) begin
        pulses++;
        pulse_at = i;
      end
      next_cyc();
    end
    chk("wdog_pulses", pulses, 32'd1);
    chk("wdog_at", pulse_at, 32'd255);
    pif.stallreq_mem = 1'b0;
    @(negedge clk);
    chk("wdog_release", {26'h0, pif.stall_o}, 32'h0);

    // Reset asserted in first RECOVER cycle aborts the sequence
    next_cyc();
    pif.excepttype_i = 32'h1;
    next_cyc();
    pif.excepttype_i = 32'h0;
    next_cyc();
    chk("abort_pre", {26'h0, pif.stall_o}, 32'h1);
    pif.stallreq_mem = 1'b1;
    pif.excepttype_i = 32'h8;
    rst_n = 1'b0;
    #1;
    chk("abort_stall", {26'h0, pif.stall_o}, 32'h0);
    chk("abort_flush", {31'h0, pif.flush_o}, 32'h0);
    chk("abort_newpc", pif.new_pc_o, 32'h0);
    chk("abort_tmo", {31'h0, pif.stall_timeout_o}, 32'h0);
    next_cyc();
    clr_in();
    rst_n = 1'b1;
    pif.stallreq_id = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", {26'h0, pif.stall_o}, 32'h0000_0007);
    chk("post_rst_flush", {31'h0, pif.flush_o}, 32'h0);
    next_cyc();
    clr_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0020, is the common exception handler entry address.
REQ-002 Parameter RECOVER_CYCLES, default 2, sets the PC hold length after a flush (legal 1..7).
REQ-003 Parameter WDOG_LIMIT, default 8'd255, sets the continuous-stall count that raises a timeout.
REQ-004 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port stallreq_id  in  1  ID-stage hold request (load-use hazard).
REQ-007 Port stallreq_ex  in  1  EX-stage hold request (multi-cycle mult/div).
REQ-008 Port stallreq_mem  in  1  MEM-stage hold request (bus wait).
REQ-009 Port excepttype_i  in  32  MEM-stage exception type; zero means none.
REQ-010 Port cp0_epc_i  in  32  current CP0 EPC value.
REQ-011 Port stall_o  out  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-012 Port flush_o  out  1  clears all pipeline registers, including MEM/WB and its CP0 write fields.
REQ-013 Port new_pc_o  out  32  redirect target, valid while flush_o=1.
REQ-014 Port stall_timeout_o  out  1  one-cycle pulse when the stall watchdog expires.

Function
REQ-015 The FSM SHALL have the states RUN, FLUSH and RECOVER.
REQ-016 In RUN with excepttype_i nonzero, flush_o SHALL be 1 combinationally, stall_o SHALL be 6'b000000, and the next state SHALL be FLUSH.
REQ-017 new_pc_o SHALL be cp0_epc_i for excepttype 32'h0000_000e (eret); for codes 0x1, 0x8, 0x9, 0xa, 0xc and 0xd it SHALL be EXC_VECTOR; for any other nonzero code it SHALL also be EXC_VECTOR; otherwise it SHALL be 0.
REQ-018 In FLUSH, flush_o=0 and stall_o=6'b000001 for one cycle, then the state SHALL become RECOVER with the counter loaded to RECOVER_CYCLES-1.
REQ-019 In RECOVER, stall_o=6'b000001 and the counter SHALL decrement each cycle; at 0 the state SHALL return to RUN.
REQ-020 Exceptions SHALL be ignored in FLUSH and RECOVER, because the flushed stages carry no valid exception.
REQ-021 Stall requests SHALL be ignored in FLUSH and RECOVER.
REQ-022 In RUN with no exception, stall priority SHALL be mem > ex > id, encoded as 6'b011111, 6'b001111 and 6'b000111 respectively; with no request, stall_o SHALL be 6'b000000.
REQ-023 An exception SHALL override any simultaneous stall request in the same cycle.
REQ-024 The watchdog counter (8-bit) SHALL increment each RUN cycle in which stall_o is nonzero, and clear on any non-stalled cycle or state change.
REQ-025 When the watchdog counter equals WDOG_LIMIT-1 and the stall persists, stall_timeout_o SHALL pulse for one cycle and the counter SHALL saturate at WDOG_LIMIT, producing no further pulses until it clears.
REQ-026 stall_timeout_o SHALL NOT itself alter stall_o or flush_o; the consumer decides the response.

Reset
REQ-027 While rst_n=0: state=RUN, counters=0, stall_o=0, flush_o=0, new_pc_o=0 and stall_timeout_o=0, regardless of inputs.
REQ-028 Assertion of rst_n mid-FLUSH or mid-RECOVER SHALL abort the sequence immediately; after release the block SHALL resume in RUN.

Structure
REQ-029 A shared defines package SHALL hold the exception codes, the stall patterns (STALL_NONE, STALL_ID, STALL_EX, STALL_MEM, STALL_PC), the FSM state encodings and EXC_VECTOR.
REQ-030 The watchdog SHALL be a sub-module, stall_wdog (clk, rst_n, en, clr, timeout), instantiated once.

Verification
REQ-031 stallreq_ex=1 for 40 cycles -> stall_o=6'b001111 on each of those cycles; no timeout pulse; stall_o=0 the cycle after release.
REQ-032 stallreq_id=1, stallreq_mem=1 and excepttype_i=32'h8 in the same cycle -> flush_o=1, new_pc_o=32'h20, stall_o=0; then 1 FLUSH cycle + 2 RECOVER cycles with stall_o=6'b000001; RUN again on the 4th cycle.
REQ-033 excepttype_i=32'he with cp0_epc_i=32'hBFC0_0100 -> new_pc_o=32'hBFC0_0100 during flush_o=1.
REQ-034 stallreq_mem held 300 cycles -> exactly one stall_timeout_o pulse, on the 255th stalled cycle.
REQ-035 rst_n=0 asserted in the first RECOVER cycle -> all outputs 0 immediately; after release, stallreq_id=1 -> stall_o=6'b000111 the same cycle.
REQ-036 excepttype_i nonzero during RECOVER -> flush_o stays 0 and the sequence length is unchanged.
